// File: rtl/popcount_ternary_neuron_if.sv
// popcount_ternary_neuron_if: beat-in / result-out handshake bundle for the ternary neuron
interface popcount_ternary_neuron_if #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [CNT_W-1:0] pos_count;
  logic [CNT_W-1:0] neg_count;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [1:0]       out_act;
  logic             out_ovf;
  modport master (
    output in_valid, in_last, pos_count, neg_count, out_ready,
    input  in_ready, out_valid, out_sum, out_act, out_ovf
  );
  modport slave (
    input  in_valid, in_last, pos_count, neg_count, out_ready,
    output in_ready, out_valid, out_sum, out_act, out_ovf
  );
endinterface

// File: rtl/popcount_ternary_neuron.sv
// popcount_ternary_neuron: accumulates saturated (pos - neg) per packet and thresholds it into {+1,0,-1}
module popcount_ternary_neuron #(
  parameter int CNT_W     = 5,
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 16,
  parameter int THRESH_HI = 4,
  parameter int THRESH_LO = -4
) (
  input logic clk,
  input logic rst,
  popcount_ternary_neuron_if.slave io
);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HI   = ACC_W'(THRESH_HI);
  localparam logic signed [ACC_W-1:0] LO   = ACC_W'(THRESH_LO);
  typedef enum logic {ACC, HOLD} state_t;
  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    ovf_q, ovf_d, oovf_q, oovf_d;
  logic [1:0]              act_q, act_d;
  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W-1:0] nxt;
  logic                    clamp, term, accept;
  // one guard bit is enough: a single beat moves acc by at most 2^CNT_W-1
  assign wide   = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(io.pos_count) - (ACC_W+1)'(io.neg_count);
  assign clamp  = wide[ACC_W] ^ wide[ACC_W-1];
  assign nxt    = clamp ? (wide[ACC_W] ? SMIN : SMAX) : wide[ACC_W-1:0];
  assign term   = io.in_last | (beat_q == BW'(MAX_BEATS - 1));
  assign accept = io.in_valid & (state_q == ACC);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    act_d   = act_q;
    oovf_d  = oovf_q;
    if (accept && term) begin
      state_d = HOLD;
      acc_d   = '0;
      beat_d  = '0;
      ovf_d   = 1'b0;
      sum_d   = nxt;
      act_d   = nxt >= HI ? 2'b01 : nxt <= LO ? 2'b11 : 2'b00;
      oovf_d  = ovf_q | clamp | ~io.in_last;
    end else if (accept) begin
      acc_d  = nxt;
      beat_d = beat_q + 1'b1;
      ovf_d  = ovf_q | clamp;
    end else if (state_q == HOLD && io.out_ready) begin
      state_d = ACC;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      act_q   <= 2'b00;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      act_q   <= act_d;
      oovf_q  <= oovf_d;
    end
  end
  assign io.in_ready  = state_q == ACC;
  assign io.out_valid = state_q == HOLD;
  assign io.out_sum   = sum_q;
  assign io.out_act   = act_q;
  assign io.out_ovf   = oovf_q;
endmodule
